// File: rtl/alu_pkg.sv
// Shared opcode/state definitions for the multicycle ALU.
// ALU_MULH_EN controls whether MULH/MULHU count as iterative ops.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_XOR   = 4'b0110,
    OP_EQ    = 4'b1000,
    OP_MUL   = 4'b1001,
    OP_MULH  = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } alu_state_e;

  // True for ops that go through the shift/add-subtract core.
  function automatic logic is_iterative(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
`ifdef ALU_MULH_EN
      OP_MULH, OP_MULHU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Shared radix-2 datapath: shift-add multiply (mode=0) or restoring divide
// (mode=1) on unsigned magnitudes, one bit per cycle for W cycles.
// Multiply: {hi,lo} ends as the 2W product. Divide: lo = quotient, hi = remainder.
module alu_seq_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         kill,
  input  logic         load,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  b_r;
  logic          mode_r;
  logic [W:0]    x, y, s;
  logic [W-1:0]  hi_n, lo_n;

  // One shared W+1 adder: hi + (lo[0] ? b : 0) for multiply,
  // {hi,lo msb} - b (two's complement add) for divide.
  assign x = mode_r ? {hi, lo[W-1]} : {1'b0, hi};
  assign y = mode_r ? ~{1'b0, b_r} : (lo[0] ? {1'b0, b_r} : '0);
  assign s = x + y + {{W{1'b0}}, mode_r};

  assign done = (cnt == '0);

  // Next partial product / partial remainder for one iteration.
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    if (mode_r) begin
      // Non-negative difference (no borrow) means the divisor fits.
      if (!s[W]) begin
        hi_n = s[W-1:0];
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = x[W-1:0];
        lo_n = {lo[W-2:0], 1'b0};
      end
    end else begin
      hi_n = s[W:1];
      lo_n = {s[0], lo[W-1:1]};
    end
  end

  // Load operands, then iterate until the counter drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      cnt    <= '0;
    end else if (kill) begin
      cnt <= '0;
    end else if (load) begin
      hi     <= '0;
      lo     <= a;
      b_r    <= b;
      mode_r <= mode;
      cnt    <= CW'(W);
    end else if (cnt != '0) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops plus iterative
// MUL/DIV/REM behind a valid/ready handshake.
// Define ALU_MULH_EN to build MULH/MULHU; otherwise those codes yield 0.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero,
  output logic                     busy
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  alu_state_e state, state_n;
  logic [OP_W-1:0] op, op_q, op_n;
  logic [OPCODE_LENGTH+3:0] opx;
  logic neg_q, neg_n, ov_n, core_load, core_done;
  logic is_div, sgn_op, a_neg, b_neg, neg_acc, b_zero, ovf, special;
  logic [W-1:0] a_mag, b_mag, spec_res, single_res, fix_res, res_n;
  logic [W-1:0] core_hi, core_lo;

  // Opcodes with any bit set above the 4-bit field decode as unknown (0111).
  assign opx = {4'b0000, Operation};
  assign op  = ((opx >> 4) == '0) ? opx[3:0] : 4'b0111;

  assign is_div = (op[3:2] == 2'b11);
`ifdef ALU_MULH_EN
  assign sgn_op = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
`else
  assign sgn_op = (op == OP_DIV) || (op == OP_REM);
`endif
  assign a_neg   = sgn_op & SrcA[W-1];
  assign b_neg   = sgn_op & SrcB[W-1];
  assign a_mag   = a_neg ? ({W{1'b0}} - SrcA) : SrcA;
  assign b_mag   = b_neg ? ({W{1'b0}} - SrcB) : SrcB;
  // Remainder takes the dividend sign; products and quotients take signA^signB.
  assign neg_acc = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);

  assign b_zero   = (SrcB == '0);
  assign ovf      = ((op == OP_DIV) || (op == OP_REM)) && (SrcA == MINV) && (SrcB == '1);
  assign special  = is_div && (b_zero || ovf);
  assign spec_res = b_zero ? (op[1] ? SrcA : '1) : (op[1] ? '0 : MINV);

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign busy     = (state != IDLE);
  assign Zero     = (ALUResult == '0);

  alu_seq_core #(.W(W)) u_core (
    .clk  (clk),
    .reset(reset),
    .kill (flush),
    .load (core_load),
    .mode (is_div),
    .a    (a_mag),
    .b    (b_mag),
    .hi   (core_hi),
    .lo   (core_lo),
    .done (core_done)
  );

  // Single-cycle result; unknown codes give 0.
  always_comb begin
    single_res = '0;
    case (op)
      OP_AND:  single_res = SrcA & SrcB;
      OP_OR:   single_res = SrcA | SrcB;
      OP_ADD:  single_res = SrcA + SrcB;
      OP_SUB:  single_res = SrcA - SrcB;
      OP_XOR:  single_res = SrcA ^ SrcB;
      OP_EQ:   single_res = {{(W-1){1'b0}}, (SrcA == SrcB)};
      default: single_res = '0;
    endcase
  end

`ifdef ALU_MULH_EN
  logic [2*W-1:0] prod_s;
  assign prod_s = neg_q ? ({(2*W){1'b0}} - {core_hi, core_lo}) : {core_hi, core_lo};
`endif

  // Sign correction and half/quotient/remainder select after iteration.
  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:           fix_res = core_lo;
`ifdef ALU_MULH_EN
      OP_MULH, OP_MULHU: fix_res = prod_s[2*W-1:W];
`endif
      OP_DIV, OP_DIVU:  fix_res = neg_q ? ({W{1'b0}} - core_lo) : core_lo;
      OP_REM, OP_REMU:  fix_res = neg_q ? ({W{1'b0}} - core_hi) : core_hi;
      default:          fix_res = '0;
    endcase
  end

  // Next state, result and handshake; flush overrides everything.
  always_comb begin
    state_n   = state;
    ov_n      = out_valid;
    res_n     = ALUResult;
    op_n      = op_q;
    neg_n     = neg_q;
    core_load = 1'b0;
    if (flush) begin
      state_n = IDLE;
      ov_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid && out_ready) ov_n = 1'b0;
          if (in_valid && in_ready) begin
            if (is_iterative(op) && !special) begin
              state_n   = is_div ? DIV : MUL;
              core_load = 1'b1;
              op_n      = op;
              neg_n     = neg_acc;
            end else begin
              res_n = special ? spec_res : single_res;
              ov_n  = 1'b1;
            end
          end
        end
        MUL, DIV: if (core_done) state_n = FIX;
        FIX: begin
          res_n   = fix_res;
          ov_n    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, result and pending-op registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= ov_n;
      ALUResult <= res_n;
      op_q      <= op_n;
      neg_q     <= neg_n;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized + directed bench for alu_multicycle against a behavioural model.
// Honours ALU_MULH_EN the same way the design does.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, Zero, busy;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic [3:0]  Operation;
  logic        rand_rdy;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct packed { logic [3:0] op; logic [31:0] a, b, r; } vec_t;
  typedef struct { logic [31:0] res; int due; bit iter; } exp_t;
  exp_t q[$];

  alu_multicycle dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference result straight from the arithmetic definitions.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, b);
    logic [63:0] p;
    logic ovf;
    logic [31:0] r;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 32'h0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h3: r = a - b;
      4'h6: r = a ^ b;
      4'h8: r = (a == b) ? 32'd1 : 32'd0;
      4'h9: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
`ifdef ALU_MULH_EN
      4'hA: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      4'hB: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
`endif
      4'hC: if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = 32'h8000_0000; else r = $signed(a) / $signed(b);
      4'hD: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      4'hE: if (b == 0) r = a; else if (ovf) r = 32'h0; else r = $signed(a) % $signed(b);
      4'hF: if (b == 0) r = a; else r = a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic bit model_iter(input logic [3:0] op, input logic [31:0] a, b);
    bit ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      4'h9: return 1'b1;
`ifdef ALU_MULH_EN
      4'hA, 4'hB: return 1'b1;
`endif
      4'hC, 4'hE: return (b != 0) && !ovf;
      4'hD, 4'hF: return (b != 0);
      default: return 1'b0;
    endcase
  endfunction

  // Directed vectors with hand-computed results.
  function automatic vec_t dvec(input int i);
    vec_t v;
    case (i)
      0:  v = '{4'h2, 32'd7, 32'd5, 32'd12};
      1:  v = '{4'h3, 32'd3, 32'd5, 32'hFFFF_FFFE};
      2:  v = '{4'h6, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00};
      3:  v = '{4'h8, 32'd9, 32'd9, 32'd1};
      4:  v = '{4'h9, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB};
`ifdef ALU_MULH_EN
      5:  v = '{4'hA, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF};
      6:  v = '{4'hB, 32'hFFFF_FFFF, 32'd2, 32'd1};
`else
      5:  v = '{4'hA, 32'hFFFF_FFFD, 32'd7, 32'd0};
      6:  v = '{4'hB, 32'hFFFF_FFFF, 32'd2, 32'd0};
`endif
      7:  v = '{4'hC, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
      8:  v = '{4'hE, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
      9:  v = '{4'hD, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA};
      10: v = '{4'hF, 32'h8000_0000, 32'd3, 32'd2};
      11: v = '{4'hC, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF};
      12: v = '{4'hF, 32'd13, 32'd0, 32'd13};
      13: v = '{4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      default: v = '{4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Compare process: all DUT checks happen here, once per cycle at negedge.
  initial begin : monitor
    vec_t v;
    bit ov_e, by_e, ir_e;
    exp_t e;
    for (int i = 0; i < 15; i++) begin
      v = dvec(i);
      chk($sformatf("model_pin%0d", i), model(v.op, v.a, v.b), v.r);
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", {31'b0, Zero}, 32'd1);
      end else begin
        ov_e = 1'b0;
        by_e = 1'b0;
        if (q.size() > 0) begin
          ov_e = (cyc >= q[0].due);
          by_e = q[0].iter && !ov_e;
        end
        ir_e = !by_e && (!ov_e || out_ready) && !flush;
        chk("out_valid", {31'b0, out_valid}, {31'b0, ov_e});
        chk("busy", {31'b0, busy}, {31'b0, by_e});
        chk("in_ready", {31'b0, in_ready}, {31'b0, ir_e});
        if (ov_e) begin
          chk("result", ALUResult, q[0].res);
          chk("zero", {31'b0, Zero}, {31'b0, (q[0].res == 32'd0)});
        end
        if (flush) q.delete();
        else begin
          if (ov_e && out_ready) void'(q.pop_front());
          if (in_valid && ir_e) begin
            e.iter = model_iter(Operation, SrcA, SrcB);
            e.res  = model(Operation, SrcA, SrcB);
            e.due  = cyc + 1 + (e.iter ? 34 : 0);
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      $display("FAIL issue_timeout: in_ready stayed 0 for op %h, expected 1", op);
      $fatal(1, "handshake timeout");
    end
  endtask

  task automatic issue_vec(input int i);
    vec_t v;
    v = dvec(i);
    issue(v.op, v.a, v.b);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin : driver
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rand_rdy = 1'b0;
    SrcA = '0; SrcB = '0; Operation = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // single-cycle ops back-to-back
    for (int i = 0; i < 4; i++) issue_vec(i);
    tick();
    // multiply, divide, special cases
    for (int i = 4; i < 15; i++) issue_vec(i);
    repeat (40) tick();

    // backpressure: DIV result held, then consumed in the same edge an ADD is accepted
    out_ready = 1'b0;
    issue(4'hC, 32'd100, 32'd7);
    repeat (45) tick();
    Operation = 4'h2; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
    repeat (3) tick();
    out_ready = 1'b1;
    issue(4'h2, 32'd1, 32'd1);
    repeat (3) tick();

    // flush mid-MUL, then asynchronous reset mid-DIV
    issue(4'h9, 32'd12345, 32'd678);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (30) tick();
    issue(4'hC, 32'd1000, 32'd7);
    repeat (15) tick();
    #2 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    issue(4'hF, 32'd1000, 32'd7);
    repeat (40) tick();

    // randomized traffic with random backpressure and flushes
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 19))
        0: begin flush = 1'b1; tick(); flush = 1'b0; end
        1: repeat ($urandom_range(0, 40)) tick();
        default: issue(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
      endcase
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
